// File: rtl/inst_fetch.sv
// Fetch stage: owns the PC, reads the combinational instruction memory and
// fills the IF/ID register. It halts on a null word, out-of-range fetch or misaligned redirect.
module inst_fetch #(
  parameter logic [31:0] RESET_PC       = 32'h0040_0000,
  parameter logic [29:0] MEM_FIRST_WORD = 30'h0010_0000,
  parameter logic [29:0] MEM_LAST_WORD  = 30'h0010_0090
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [29:0] read_addr,
  input  logic [31:0] memout,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        halted,
  output logic [1:0]  halt_cause,
  output logic [31:0] inst_count
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  localparam logic [1:0] CAUSE_NULL  = 2'd1;
  localparam logic [1:0] CAUSE_RANGE = 2'd2;
  localparam logic [1:0] CAUSE_ALIGN = 2'd3;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_next_seq;
  logic        in_range;
  logic        null_word;

  function automatic logic [31:0] add4(input logic [31:0] a);
    return a + 32'd4;
  endfunction

  assign read_addr   = pc[31:2];
  assign pc_next_seq = add4(pc);
  assign in_range    = (pc[31:2] >= MEM_FIRST_WORD) && (pc[31:2] <= MEM_LAST_WORD);
  assign null_word   = (memout == 32'h0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      pc          <= RESET_PC;
      if_valid    <= 1'b0;
      if_inst     <= 32'h0;
      if_pc       <= 32'h0;
      if_pc_plus4 <= 32'h0;
      halted      <= 1'b0;
      halt_cause  <= 2'd0;
      inst_count  <= 32'h0;
    end else begin
      case (state)
        RUN: begin
          if (redirect_valid) begin
            // Wrong-path word is squashed whether or not the target is usable.
            if_valid <= 1'b0;
            if (redirect_pc[1:0] != 2'b00) begin
              state      <= HALT;
              halted     <= 1'b1;
              halt_cause <= CAUSE_ALIGN;
            end else begin
              pc <= redirect_pc;
            end
          end else if (stall) begin
            // Hold everything; checks wait until the stall releases.
          end else if (!in_range) begin
            state      <= HALT;
            halted     <= 1'b1;
            halt_cause <= CAUSE_RANGE;
            if_valid   <= 1'b0;
          end else if (null_word) begin
            state      <= HALT;
            halted     <= 1'b1;
            halt_cause <= CAUSE_NULL;
            if_valid   <= 1'b0;
          end else begin
            if_inst     <= memout;
            if_pc       <= pc;
            if_pc_plus4 <= pc_next_seq;
            if_valid    <= 1'b1;
            pc          <= pc_next_seq;
            inst_count  <= inst_count + 32'd1;
          end
        end
        HALT: begin
          if_valid <= 1'b0;
          halted   <= 1'b1;
        end
        default: begin
          state <= HALT;
        end
      endcase
    end
  end

endmodule
